// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the core and a
// loader/debug port, with one outstanding read and round-robin on conflict.
module dmem_arbiter #(
  parameter int N  = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_re,
  input  logic          c_we,
  input  logic [AW-1:0] c_ad,
  input  logic [N-1:0]  c_d,
  output logic [N-1:0]  c_q,
  output logic          c_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_ad,
  input  logic [N-1:0]  l_d,
  output logic          l_gnt,
  output logic [N-1:0]  l_q,
  output logic          l_valid,
  output logic          m_re,
  output logic          m_we,
  output logic [AW-1:0] m_ad,
  output logic [N-1:0]  m_d,
  input  logic [N-1:0]  m_q,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    C_RDW = 2'd1,
    L_RDW = 2'd2
  } state_t;

  localparam logic LAST_CORE = 1'b0;
  localparam logic LAST_LDR  = 1'b1;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [N-1:0]   c_hold_q, c_hold_d;
  logic [N-1:0]   l_hold_q, l_hold_d;
  logic           err_q, err_d;

  logic           c_req_s;
  logic           c_rd_s;
  logic           gnt_c_s;
  logic           gnt_l_s;
  logic           c_stall_s;

  // Grant selection, memory command, next state and hold-register updates
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    c_hold_d  = c_hold_q;
    l_hold_d  = l_hold_q;
    err_d     = err_q | (c_re & c_we);
    gnt_c_s   = 1'b0;
    gnt_l_s   = 1'b0;
    m_re      = 1'b0;
    m_we      = 1'b0;
    m_ad      = {AW{1'b0}};
    m_d       = {N{1'b0}};
    c_q       = c_hold_q;
    l_q       = l_hold_q;
    l_valid   = 1'b0;
    c_req_s   = c_re | c_we;
    // A simultaneous load+store from the core is executed as a store
    c_rd_s    = c_re & ~c_we;
    c_stall_s = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_c_s = c_req_s & (~l_req | (last_q == LAST_LDR));
        gnt_l_s = l_req & (~c_req_s | (last_q == LAST_CORE));
        if (gnt_c_s) begin
          m_ad   = c_ad;
          m_d    = c_d;
          m_we   = c_we;
          m_re   = c_rd_s;
          last_d = LAST_CORE;
          if (c_rd_s) begin
            state_d = C_RDW;
          end else begin
            state_d = IDLE;
          end
        end else if (gnt_l_s) begin
          m_ad   = l_ad;
          m_d    = l_d;
          m_we   = l_we;
          m_re   = ~l_we;
          last_d = LAST_LDR;
          if (!l_we) begin
            state_d = L_RDW;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
        c_stall_s = (c_req_s & ~gnt_c_s) | (gnt_c_s & c_rd_s);
      end
      C_RDW: begin
        c_q       = m_q;
        c_hold_d  = m_q;
        state_d   = IDLE;
        c_stall_s = 1'b0;
      end
      L_RDW: begin
        l_q       = m_q;
        l_hold_d  = m_q;
        l_valid   = 1'b1;
        state_d   = IDLE;
        c_stall_s = c_req_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep handshake and command strobes quiet while reset is held
    c_stall = c_stall_s & rst;
    l_gnt   = gnt_l_s & rst;
    m_re    = m_re & rst;
    m_we    = m_we & rst;
  end

  assign err = err_q;

  // State, fairness pointer, read-data holds and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= LAST_LDR;
      c_hold_q <= {N{1'b0}};
      l_hold_q <= {N{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      c_hold_q <= c_hold_d;
      l_hold_q <= l_hold_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: drives after the falling
// edge, compares 1 time unit later, well before the next rising edge.
module tb_dmem_arbiter;

  localparam int N  = 32;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          c_re, c_we;
  logic [AW-1:0] c_ad;
  logic [N-1:0]  c_d;
  logic [N-1:0]  c_q;
  logic          c_stall;
  logic          l_req, l_we;
  logic [AW-1:0] l_ad;
  logic [N-1:0]  l_d;
  logic          l_gnt;
  logic [N-1:0]  l_q;
  logic          l_valid;
  logic          m_re, m_we;
  logic [AW-1:0] m_ad;
  logic [N-1:0]  m_d;
  logic [N-1:0]  m_q;
  logic          err;

  int vecs;
  int errs;

  // {c_stall, l_gnt, m_re, m_we, l_valid, err}
  logic [5:0] ctl;
  assign ctl = {c_stall, l_gnt, m_re, m_we, l_valid, err};

  dmem_arbiter #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .c_re(c_re), .c_we(c_we), .c_ad(c_ad), .c_d(c_d), .c_q(c_q), .c_stall(c_stall),
    .l_req(l_req), .l_we(l_we), .l_ad(l_ad), .l_d(l_d), .l_gnt(l_gnt), .l_q(l_q),
    .l_valid(l_valid),
    .m_re(m_re), .m_we(m_we), .m_ad(m_ad), .m_d(m_d), .m_q(m_q), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_re = 1'b0; c_we = 1'b0; c_ad = 8'h00; c_d = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_ad = 8'h00; l_d = 32'h0;
    m_q = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    c_re = 1'b1; l_req = 1'b1; c_we = 1'b0; l_we = 1'b0;
    #1;
    vecs++;
    if (ctl !== 6'b000000) begin
      errs++; $display("FAIL reset_ctl: got %b want %b", ctl, 6'b000000);
    end
    vecs++;
    if (c_q !== 32'h0 || l_q !== 32'h0) begin
      errs++; $display("FAIL reset_data: got c_q=%h l_q=%h want 0/0", c_q, l_q);
    end
    do_reset();
  endtask

  task automatic test_core_load();
    @(negedge clk);
    c_re = 1'b1; c_ad = 8'h10;
    #1;
    vecs++;
    if (ctl !== 6'b101000 || m_ad !== 8'h10) begin
      errs++; $display("FAIL cload_grant: got ctl=%b m_ad=%h want 101000/10", ctl, m_ad);
    end
    @(negedge clk);
    c_re = 1'b0; m_q = 32'hDEADBEEF;
    #1;
    vecs++;
    if (ctl !== 6'b000000 || c_q !== 32'hDEADBEEF) begin
      errs++; $display("FAIL cload_wait: got ctl=%b c_q=%h want 000000/deadbeef", ctl, c_q);
    end
    @(negedge clk);
    m_q = 32'h12345678;
    #1;
    vecs++;
    if (c_q !== 32'hDEADBEEF) begin
      errs++; $display("FAIL cload_hold: got %h want deadbeef", c_q);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    c_we = 1'b1; c_ad = 8'h20; c_d = 32'hA5A5A5A5;
    l_req = 1'b1; l_we = 1'b0; l_ad = 8'h30;
    #1;
    vecs++;
    if (ctl !== 6'b000100 || m_ad !== 8'h20 || m_d !== 32'hA5A5A5A5) begin
      errs++; $display("FAIL conflict_core: got ctl=%b m_ad=%h m_d=%h want 000100/20/a5a5a5a5",
                       ctl, m_ad, m_d);
    end
    @(negedge clk);
    c_we = 1'b0;
    #1;
    vecs++;
    if (ctl !== 6'b011000 || m_ad !== 8'h30) begin
      errs++; $display("FAIL conflict_ldr: got ctl=%b m_ad=%h want 011000/30", ctl, m_ad);
    end
    @(negedge clk);
    l_req = 1'b0; m_q = 32'hCAFEF00D;
    #1;
    vecs++;
    if (ctl !== 6'b000010 || l_q !== 32'hCAFEF00D) begin
      errs++; $display("FAIL conflict_lvalid: got ctl=%b l_q=%h want 000010/cafef00d", ctl, l_q);
    end
    @(negedge clk);
    m_q = 32'h0;
    #1;
    vecs++;
    if (ctl !== 6'b000000 || l_q !== 32'hCAFEF00D) begin
      errs++; $display("FAIL conflict_lhold: got ctl=%b l_q=%h want 000000/cafef00d", ctl, l_q);
    end
  endtask

  task automatic test_loader_write();
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b1; l_ad = 8'h7F; l_d = 32'h0BADF00D;
    #1;
    vecs++;
    if (ctl !== 6'b010100 || m_ad !== 8'h7F || m_d !== 32'h0BADF00D) begin
      errs++; $display("FAIL lwrite: got ctl=%b m_ad=%h m_d=%h want 010100/7f/0badf00d",
                       ctl, m_ad, m_d);
    end
    @(negedge clk);
    l_req = 1'b0; l_we = 1'b0;
    #1;
    vecs++;
    if (ctl !== 6'b000000) begin
      errs++; $display("FAIL lwrite_after: got ctl=%b want 000000", ctl);
    end
  endtask

  task automatic test_fairness();
    // Pointer is at loader after the loader write, so the core wins first
    int lgnt_cycle;
    logic [5:0] exp_ctl [0:4];
    exp_ctl[0] = 6'b101000;
    exp_ctl[1] = 6'b000000;
    exp_ctl[2] = 6'b111000;
    exp_ctl[3] = 6'b100010;
    exp_ctl[4] = 6'b101000;
    lgnt_cycle = -1;
    @(negedge clk);
    c_re = 1'b1; c_ad = 8'h40; l_req = 1'b1; l_we = 1'b0; l_ad = 8'h50;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      m_q = 32'h1000 + i;
      if (i == 3) l_req = 1'b0;
      #1;
      if (l_gnt === 1'b1 && lgnt_cycle < 0) lgnt_cycle = i;
      vecs++;
      if (ctl !== exp_ctl[i]) begin
        errs++; $display("FAIL fair_cycle%0d: got ctl=%b want %b", i, ctl, exp_ctl[i]);
      end
      if (i == 1) begin
        vecs++;
        if (c_q !== 32'h1001) begin
          errs++; $display("FAIL fair_cq: got %h want 00001001", c_q);
        end
      end
      if (i == 3) begin
        vecs++;
        if (l_q !== 32'h1003) begin
          errs++; $display("FAIL fair_lq: got %h want 00001003", l_q);
        end
      end
    end
    vecs++;
    if (lgnt_cycle < 0 || lgnt_cycle > 3) begin
      errs++; $display("FAIL fair_bound: loader granted at cycle %0d want 0..3", lgnt_cycle);
    end
    @(negedge clk);
    c_re = 1'b0;
    next_cycle();
  endtask

  task automatic test_err();
    @(negedge clk);
    idle_inputs();
    c_re = 1'b1; c_we = 1'b1; c_ad = 8'h44; c_d = 32'h11111111;
    #1;
    vecs++;
    if (ctl !== 6'b000100 || m_ad !== 8'h44 || m_d !== 32'h11111111) begin
      errs++; $display("FAIL err_as_write: got ctl=%b m_ad=%h m_d=%h want 000100/44/11111111",
                       ctl, m_ad, m_d);
    end
    @(negedge clk);
    c_re = 1'b0; c_we = 1'b0;
    #1;
    vecs++;
    if (err !== 1'b1) begin
      errs++; $display("FAIL err_set: got %b want 1", err);
    end
    next_cycle();
    next_cycle();
    vecs++;
    if (err !== 1'b1) begin
      errs++; $display("FAIL err_sticky: got %b want 1", err);
    end
    do_reset();
    vecs++;
    if (err !== 1'b0) begin
      errs++; $display("FAIL err_clear: got %b want 0", err);
    end
  endtask

  task automatic test_reset_in_lrdw();
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b0; l_ad = 8'h66;
    #1;
    vecs++;
    if (ctl !== 6'b011000) begin
      errs++; $display("FAIL rstrd_grant: got ctl=%b want 011000", ctl);
    end
    @(negedge clk);
    l_req = 1'b0; m_q = 32'h55AA55AA;
    #1;
    vecs++;
    if (l_valid !== 1'b1 || l_q !== 32'h55AA55AA) begin
      errs++; $display("FAIL rstrd_inflight: got l_valid=%b l_q=%h want 1/55aa55aa", l_valid, l_q);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (ctl !== 6'b000000 || l_q !== 32'h0) begin
      errs++; $display("FAIL rstrd_async: got ctl=%b l_q=%h want 000000/0", ctl, l_q);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (ctl !== 6'b000000 || c_q !== 32'h0 || l_q !== 32'h0 || m_ad !== 8'h0 || m_d !== 32'h0)
      begin
        errs++; $display("FAIL rstrd_after%0d: got ctl=%b c_q=%h l_q=%h m_ad=%h m_d=%h want all 0",
                         i, ctl, c_q, l_q, m_ad, m_d);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_core_load();
    test_conflict();
    test_loader_write();
    test_fairness();
    test_err();
    test_reset_in_lrdw();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter N, 32, data width in bits.
REQ-002 The block SHALL have parameter AW, 8, data memory address width in bits.
REQ-003 The block SHALL have port clk  in  1  clock, rising-edge active.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port c_re  in  1  core load request.
REQ-006 The block SHALL have port c_we  in  1  core store request.
REQ-007 The block SHALL have port c_ad  in  AW  core address.
REQ-008 The block SHALL have port c_d  in  N  core store data.
REQ-009 The block SHALL have port c_q  out  N  core load data.
REQ-010 The block SHALL have port c_stall  out  1  core must hold its request and freeze its PC.
REQ-011 The block SHALL have port l_req  in  1  loader/debug request.
REQ-012 The block SHALL have port l_we  in  1  loader write (1) or read (0), qualified by l_req.
REQ-013 The block SHALL have port l_ad  in  AW  loader address.
REQ-014 The block SHALL have port l_d  in  N  loader write data.
REQ-015 The block SHALL have port l_gnt  out  1  loader request accepted this cycle.
REQ-016 The block SHALL have port l_q  out  N  loader read data.
REQ-017 The block SHALL have port l_valid  out  1  l_q valid, one-cycle pulse.
REQ-018 The block SHALL have ports m_re, m_we  out  1 each; m_ad  out  AW; m_d  out  N  memory command.
REQ-019 The block SHALL have port m_q  in  N  memory read data, valid the cycle after m_re.
REQ-020 The block SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-021 The FSM SHALL have states IDLE, C_RDW (core read wait) and L_RDW (loader read wait); at most one read SHALL be outstanding.
REQ-022 In IDLE, with a single requester, the requester SHALL be granted that cycle; with both requesting, the requester other than the last-granted (1-bit pointer `last`) SHALL be granted.
REQ-023 A granted access SHALL drive m_ad/m_d/m_we/m_re combinationally from the winner in the grant cycle; m_re and m_we SHALL be 0 when there is no grant.
REQ-024 A granted write SHALL complete in the grant cycle, and the FSM SHALL stay in IDLE.
REQ-025 A granted read SHALL move the FSM to C_RDW or L_RDW; that wait cycle SHALL return the FSM to IDLE; no grant SHALL be issued in a wait state.
REQ-026 c_stall SHALL be 1 when (c_re|c_we) and the core is not granted this cycle, or the core read is granted this cycle; c_stall SHALL be 0 otherwise, including in C_RDW.
REQ-027 In C_RDW, c_q SHALL equal m_q and be captured into a hold register; in all other cycles c_q SHALL present the hold register.
REQ-028 l_gnt SHALL pulse 1 in each loader grant cycle; in L_RDW, l_valid SHALL be 1 and l_q SHALL equal m_q (registered copy held afterwards).
REQ-029 `last` SHALL update to the winner on every grant.
REQ-030 Loader wait SHALL be bounded: under continuous core traffic the loader SHALL be granted within 3 cycles of l_req rising.
REQ-031 c_re and c_we both 1 SHALL be treated as a write, and err SHALL be set.
REQ-032 err SHALL remain set until reset.
REQ-033 A requester SHALL hold its request until granted; the block SHALL NOT queue requests.

Reset
REQ-034 On rst low, asynchronously: state SHALL be IDLE, last SHALL be loader (core wins first conflict), and c_q, l_q hold registers, l_valid and err SHALL be 0.
REQ-035 During reset, c_stall, l_gnt, m_re and m_we SHALL be 0.
REQ-036 A read in flight when reset asserts SHALL be abandoned: no l_valid and no c_q update after release.

Verification
REQ-037 Core load only, c_ad=0x10, m_q=0xDEADBEEF the next cycle -> cycle 0 m_re=1, c_stall=1; cycle 1 c_stall=0, c_q=0xDEADBEEF, held thereafter.
REQ-038 Simultaneous core store and loader read after reset -> core granted first (m_we=1, c_stall=0, l_gnt=0); next cycle l_gnt=1, m_re=1; following cycle l_valid=1.
REQ-039 Continuous core loads plus l_req held -> grants alternate core/loader, and loader is granted within 3 cycles.
REQ-040 c_re=c_we=1 -> treated as a write, err=1, and err remains 1 until rst.
REQ-041 rst asserted during L_RDW -> after release, state is IDLE, l_valid never pulses, and all outputs are 0.
